// File: rtl/exe_stage_pkg.sv
// Shared CPU pipeline constants: bus widths, ALU op bit indices and bus layouts.
// Combinational definitions only; no latency or backpressure of its own.
package exe_stage_pkg;

    localparam int DS_TO_ES_BUS_WD = 150;
    localparam int ES_TO_MS_BUS_WD = 71;
    localparam int ALU_OP_WD       = 12;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    typedef struct packed {
        logic [ALU_OP_WD-1:0] alu_op;
        logic                 res_from_mem;
        logic                 src1_is_pc;
        logic                 src2_is_imm;
        logic                 gr_we;
        logic                 mem_we;
        logic [4:0]           dest;
        logic [31:0]          imm;
        logic [31:0]          rj_value;
        logic [31:0]          rkd_value;
        logic [31:0]          pc;
    } ds_to_es_t;

    typedef struct packed {
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

endpackage

// File: rtl/exe_stage_if.sv
// Handshake, pipeline buses, hazard/forward info and data-memory request of the EXE stage.
// master = the EXE stage itself; slave = the surrounding ID/MEM/memory side.
interface exe_stage_if;
    import exe_stage_pkg::*;

    logic                       ms_allowin;
    logic                       es_allowin;
    logic                       ds_to_es_valid;
    logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic [4:0]                 es_to_ds_dest;
    logic                       es_to_ds_load_op;
    logic                       exe_forward_valid;
    logic [4:0]                 exe_forward_addr;
    logic [31:0]                exe_forward_data;
    logic                       data_sram_en;
    logic [3:0]                 data_sram_we;
    logic [31:0]                data_sram_addr;
    logic [31:0]                data_sram_wdata;

    modport master (
        input  ms_allowin, ds_to_es_valid, ds_to_es_bus,
        output es_allowin, es_to_ms_valid, es_to_ms_bus, es_to_ds_dest, es_to_ds_load_op,
               exe_forward_valid, exe_forward_addr, exe_forward_data,
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
    );

    modport slave (
        output ms_allowin, ds_to_es_valid, ds_to_es_bus,
        input  es_allowin, es_to_ms_valid, es_to_ms_bus, es_to_ds_dest, es_to_ds_load_op,
               exe_forward_valid, exe_forward_addr, exe_forward_data,
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
    );

endinterface

// File: rtl/exe_stage_alu.sv
// Combinational 32-bit ALU driven by a one-hot op vector; zero op vector gives zero.
// Zero latency, no backpressure.
module alu
    import exe_stage_pkg::*;
(
    input  logic [ALU_OP_WD-1:0] alu_op,
    input  logic [31:0]          src1,
    input  logic [31:0]          src2,
    output logic [31:0]          result
);

    logic        sub_like;
    logic [32:0] addsub;
    logic [31:0] sum;
    logic        slt;
    logic        sltu;
    logic [4:0]  shamt;
    logic [63:0] sra_ext;

    // sub, slt and sltu share the adder as src1 + ~src2 + 1
    assign sub_like = alu_op[ALU_SUB] | alu_op[ALU_SLT] | alu_op[ALU_SLTU];
    assign addsub   = {1'b0, src1} + {1'b0, sub_like ? ~src2 : src2} + {32'b0, sub_like};
    assign sum      = addsub[31:0];
    assign slt      = (src1[31] & ~src2[31]) | (~(src1[31] ^ src2[31]) & sum[31]);
    assign sltu     = ~addsub[32];
    assign shamt    = src2[4:0];
    assign sra_ext  = {{32{src1[31]}}, src1} >> shamt;

    assign result = ({32{alu_op[ALU_ADD] | alu_op[ALU_SUB]}} & sum)
                  | ({32{alu_op[ALU_SLT]}}  & {31'b0, slt})
                  | ({32{alu_op[ALU_SLTU]}} & {31'b0, sltu})
                  | ({32{alu_op[ALU_AND]}}  & (src1 & src2))
                  | ({32{alu_op[ALU_NOR]}}  & ~(src1 | src2))
                  | ({32{alu_op[ALU_OR]}}   & (src1 | src2))
                  | ({32{alu_op[ALU_XOR]}}  & (src1 ^ src2))
                  | ({32{alu_op[ALU_SLL]}}  & (src1 << shamt))
                  | ({32{alu_op[ALU_SRL]}}  & (src1 >> shamt))
                  | ({32{alu_op[ALU_SRA]}}  & sra_ext[31:0])
                  | ({32{alu_op[ALU_LUI]}}  & src2);

endmodule

// File: rtl/exe_stage.sv
// EXE pipeline stage: one-entry register + ALU, single-cycle, stalls by holding while MEM refuses.
// ALU-result forwarding to ID exists only when EXE_FORWARD_EN is defined.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    exe_stage_if.master pipe
);

    logic        es_valid;
    ds_to_es_t   bus_r;
    logic        es_ready_go;
    logic        es_allowin;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] alu_result;
    es_to_ms_t   ms_bus;

    assign es_ready_go = 1'b1;
    assign es_allowin  = ~es_valid | (es_ready_go & pipe.ms_allowin);

    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid <= 1'b0;
        end else if (es_allowin) begin
            es_valid <= pipe.ds_to_es_valid;
        end
    end

    // payload needs no reset: every consumer is qualified by es_valid
    always_ff @(posedge clk) begin
        if (es_allowin && pipe.ds_to_es_valid) begin
            bus_r <= pipe.ds_to_es_bus;
        end
    end

    assign src1 = bus_r.src1_is_pc  ? bus_r.pc  : bus_r.rj_value;
    assign src2 = bus_r.src2_is_imm ? bus_r.imm : bus_r.rkd_value;

    alu u_alu (
        .alu_op (bus_r.alu_op),
        .src1   (src1),
        .src2   (src2),
        .result (alu_result)
    );

    assign ms_bus.res_from_mem = bus_r.res_from_mem;
    assign ms_bus.gr_we        = bus_r.gr_we;
    assign ms_bus.dest         = bus_r.dest;
    assign ms_bus.alu_result   = alu_result;
    assign ms_bus.pc           = bus_r.pc;

    assign pipe.es_allowin       = es_allowin;
    assign pipe.es_to_ms_valid   = es_valid & es_ready_go;
    assign pipe.es_to_ms_bus     = ms_bus;
    assign pipe.es_to_ds_dest    = (es_valid & bus_r.gr_we) ? bus_r.dest : 5'd0;
    assign pipe.es_to_ds_load_op = es_valid & bus_r.res_from_mem;

    assign pipe.data_sram_en    = es_valid & (bus_r.res_from_mem | bus_r.mem_we);
    assign pipe.data_sram_we    = {4{es_valid & bus_r.mem_we}};
    assign pipe.data_sram_addr  = alu_result;
    assign pipe.data_sram_wdata = bus_r.rkd_value;

`ifdef EXE_FORWARD_EN
    // loads are excluded: their value only exists after MEM
    assign pipe.exe_forward_valid = es_valid & bus_r.gr_we & ~bus_r.res_from_mem & (bus_r.dest != 5'd0);
    assign pipe.exe_forward_addr  = bus_r.dest;
    assign pipe.exe_forward_data  = alu_result;
`else
    assign pipe.exe_forward_valid = 1'b0;
    assign pipe.exe_forward_addr  = 5'd0;
    assign pipe.exe_forward_data  = 32'd0;
`endif

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed vector table, stall/reset sequences,
// and randomized traffic checked against a queue-based scoreboard.
module tb_exe_stage;

`ifdef EXE_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    exe_stage_if ifc ();

    exe_stage dut (
        .clk   (clk),
        .reset (reset),
        .pipe  (ifc)
    );

    typedef struct {
        logic [149:0] bus;
        logic [31:0]  res;
        logic         sram_en;
        logic [3:0]   we;
        logic [4:0]   ds_dest;
        logic         load;
        logic         fwd;
    } vec_t;

    function automatic logic [149:0] mk(input logic [11:0] op, input logic rfm, input logic s1pc,
                                        input logic s2imm, input logic gw, input logic mw,
                                        input logic [4:0] dest, input logic [31:0] imm,
                                        input logic [31:0] rj, input logic [31:0] rkd,
                                        input logic [31:0] pc);
        return {op, rfm, s1pc, s2imm, gw, mw, dest, imm, rj, rkd, pc};
    endfunction

    // reference ALU written straight from the operation definitions
    function automatic logic [31:0] alu_ref(input logic [11:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r = 32'd0;
        if (op[0])  r = r | (a + b);
        if (op[1])  r = r | (a - b);
        if (op[2])  r = r | (($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        if (op[3])  r = r | ((a < b) ? 32'd1 : 32'd0);
        if (op[4])  r = r | (a & b);
        if (op[5])  r = r | ~(a | b);
        if (op[6])  r = r | (a | b);
        if (op[7])  r = r | (a ^ b);
        if (op[8])  r = r | (a << b[4:0]);
        if (op[9])  r = r | (a >> b[4:0]);
        if (op[10]) r = r | 32'($signed(a) >>> b[4:0]);
        if (op[11]) r = r | b;
        return r;
    endfunction

    function automatic logic [70:0] exp_ms(input logic [149:0] b);
        logic [31:0] s1 = b[136] ? b[31:0]   : b[95:64];
        logic [31:0] s2 = b[135] ? b[127:96] : b[63:32];
        return {b[137], b[134], b[132:128], alu_ref(b[149:138], s1, s2), b[31:0]};
    endfunction

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ms_valid"}, 80'(ifc.es_to_ms_valid), 80'(0));
        chk({tag, "_allowin"},  80'(ifc.es_allowin), 80'(1));
        chk({tag, "_sram_en"},  80'(ifc.data_sram_en), 80'(0));
        chk({tag, "_sram_we"},  80'(ifc.data_sram_we), 80'(0));
        chk({tag, "_load_op"},  80'(ifc.es_to_ds_load_op), 80'(0));
        chk({tag, "_ds_dest"},  80'(ifc.es_to_ds_dest), 80'(0));
        chk({tag, "_fwd_vld"},  80'(ifc.exe_forward_valid), 80'(0));
    endtask

    vec_t        vt[12];
    logic [149:0] ia, ib, rb;
    logic [149:0] q[$];

    initial begin
        vt[0]  = '{mk(12'h001,0,0,0,1,0,5'd3, 32'h0,        32'h7FFFFFFF,32'h1,       32'h1C000000), 32'h80000000, 0, 4'h0, 5'd3, 0, 1};
        vt[1]  = '{mk(12'h400,0,0,1,1,0,5'd4, 32'h4,        32'h80000000,32'h55,      32'h1C000004), 32'hF8000000, 0, 4'h0, 5'd4, 0, 1};
        vt[2]  = '{mk(12'h004,0,0,0,1,0,5'd6, 32'h0,        32'hFFFFFFFF,32'h1,       32'h1C000008), 32'h00000001, 0, 4'h0, 5'd6, 0, 1};
        vt[3]  = '{mk(12'h008,0,0,0,1,0,5'd7, 32'h0,        32'hFFFFFFFF,32'h1,       32'h1C00000C), 32'h00000000, 0, 4'h0, 5'd7, 0, 1};
        vt[4]  = '{mk(12'h001,0,0,1,0,1,5'd0, 32'h8,        32'h00001000,32'hDEADBEEF,32'h1C000010), 32'h00001008, 1, 4'hF, 5'd0, 0, 0};
        vt[5]  = '{mk(12'h001,1,0,1,1,0,5'd5, 32'h4,        32'h00002000,32'h1234,    32'h1C000014), 32'h00002004, 1, 4'h0, 5'd5, 1, 0};
        vt[6]  = '{mk(12'h000,0,0,0,1,0,5'd9, 32'h0,        32'h123,     32'h456,     32'h1C000018), 32'h00000000, 0, 4'h0, 5'd9, 0, 1};
        vt[7]  = '{mk(12'h800,0,0,1,1,0,5'd10,32'h12345000, 32'h1,       32'h2,       32'h1C00001C), 32'h12345000, 0, 4'h0, 5'd10,0, 1};
        vt[8]  = '{mk(12'h001,0,0,0,1,0,5'd0, 32'h0,        32'h5,       32'h6,       32'h1C000020), 32'h0000000B, 0, 4'h0, 5'd0, 0, 0};
        vt[9]  = '{mk(12'h001,0,1,1,1,0,5'd1, 32'h4,        32'hFFFF,    32'h0,       32'h1C000000), 32'h1C000004, 0, 4'h0, 5'd1, 0, 1};
        vt[10] = '{mk(12'h020,0,0,0,0,0,5'd2, 32'h0,        32'hF0F0F0F0,32'h0F0F0000,32'h1C000024), 32'h00000F0F, 0, 4'h0, 5'd0, 0, 0};
        vt[11] = '{mk(12'h100,0,0,0,1,0,5'd8, 32'h0,        32'h1,       32'h21,      32'h1C000028), 32'h00000002, 0, 4'h0, 5'd8, 0, 1};

        ia = mk(12'h001,0,0,0,1,0,5'd11,32'h0,32'd10, 32'd20,32'h1C000100);
        ib = mk(12'h002,0,0,0,1,0,5'd12,32'h0,32'd100,32'd1, 32'h1C000104);

        // reset wins over an offered instruction
        reset = 1'b1;
        ifc.ms_allowin     = 1'b1;
        ifc.ds_to_es_valid = 1'b1;
        ifc.ds_to_es_bus   = ia;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ifc.ds_to_es_valid = 1'b0;
        #1 chk_idle("reset");

        foreach (vt[i]) begin
            ifc.ds_to_es_valid = 1'b1;
            ifc.ds_to_es_bus   = vt[i].bus;
            ifc.ms_allowin     = 1'b1;
            tick();
            ifc.ds_to_es_valid = 1'b0;
            #1;
            chk($sformatf("v%0d_ms_valid", i), 80'(ifc.es_to_ms_valid), 80'(1));
            chk($sformatf("v%0d_result", i),   80'(ifc.es_to_ms_bus[63:32]), 80'(vt[i].res));
            chk($sformatf("v%0d_ms_bus", i),   80'(ifc.es_to_ms_bus), 80'(exp_ms(vt[i].bus)));
            chk($sformatf("v%0d_sram_en", i),  80'(ifc.data_sram_en), 80'(vt[i].sram_en));
            chk($sformatf("v%0d_sram_we", i),  80'(ifc.data_sram_we), 80'(vt[i].we));
            chk($sformatf("v%0d_sram_addr", i),80'(ifc.data_sram_addr), 80'(vt[i].res));
            chk($sformatf("v%0d_sram_wdata", i),80'(ifc.data_sram_wdata), 80'(vt[i].bus[63:32]));
            chk($sformatf("v%0d_ds_dest", i),  80'(ifc.es_to_ds_dest), 80'(vt[i].ds_dest));
            chk($sformatf("v%0d_load_op", i),  80'(ifc.es_to_ds_load_op), 80'(vt[i].load));
            chk($sformatf("v%0d_fwd_vld", i),  80'(ifc.exe_forward_valid), 80'(FWD_EN & vt[i].fwd));
            chk($sformatf("v%0d_fwd_addr", i), 80'(ifc.exe_forward_addr), 80'(FWD_EN ? vt[i].bus[132:128] : 5'd0));
            chk($sformatf("v%0d_fwd_data", i), 80'(ifc.exe_forward_data), 80'(FWD_EN ? vt[i].res : 32'd0));
        end
        tick();
        #1 chk("drain_ms_valid", 80'(ifc.es_to_ms_valid), 80'(0));

        // stall: A held for three cycles while B waits, then A once, then B
        ifc.ds_to_es_valid = 1'b1;
        ifc.ds_to_es_bus   = ia;
        ifc.ms_allowin     = 1'b1;
        tick();
        ifc.ds_to_es_bus = ib;
        ifc.ms_allowin   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d_allowin", c),  80'(ifc.es_allowin), 80'(0));
            chk($sformatf("stall%0d_ms_valid", c), 80'(ifc.es_to_ms_valid), 80'(1));
            chk($sformatf("stall%0d_hold", c),     80'(ifc.es_to_ms_bus), 80'(exp_ms(ia)));
            tick();
        end
        ifc.ms_allowin = 1'b1;
        #1;
        chk("release_allowin", 80'(ifc.es_allowin), 80'(1));
        chk("release_old",     80'(ifc.es_to_ms_bus), 80'(exp_ms(ia)));
        tick();
        ifc.ds_to_es_valid = 1'b0;
        #1;
        chk("release_new_vld", 80'(ifc.es_to_ms_valid), 80'(1));
        chk("release_new",     80'(ifc.es_to_ms_bus), 80'(exp_ms(ib)));
        tick();
        #1 chk("release_empty", 80'(ifc.es_to_ms_valid), 80'(0));

        // reset while stalled discards the held instruction
        ifc.ds_to_es_valid = 1'b1;
        ifc.ds_to_es_bus   = ia;
        tick();
        ifc.ds_to_es_bus = ib;
        ifc.ms_allowin   = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ifc.ds_to_es_valid = 1'b0;
        ifc.ms_allowin     = 1'b1;
        #1 chk_idle("stall_reset");

        // randomized traffic against a FIFO scoreboard of accepted instructions
        q.delete();
        for (int c = 0; c < 400; c++) begin
            logic exp_allowin;
            int   k;
            ifc.ds_to_es_valid = 1'($urandom_range(0, 1));
            ifc.ms_allowin     = ($urandom_range(0, 3) != 0);
            k  = $urandom_range(0, 12);
            rb = {$urandom, $urandom, $urandom, $urandom, $urandom};
            rb[149:138] = (k == 12) ? 12'h000 : (12'h001 << k);
            ifc.ds_to_es_bus = rb;
            #1;
            exp_allowin = (q.size() == 0) || ifc.ms_allowin;
            chk("rnd_allowin",  80'(ifc.es_allowin), 80'(exp_allowin));
            chk("rnd_ms_valid", 80'(ifc.es_to_ms_valid), 80'(q.size() != 0));
            if (q.size() != 0) begin
                chk("rnd_ms_bus",  80'(ifc.es_to_ms_bus), 80'(exp_ms(q[0])));
                chk("rnd_load_op", 80'(ifc.es_to_ds_load_op), 80'(q[0][137]));
                chk("rnd_ds_dest", 80'(ifc.es_to_ds_dest), 80'(q[0][134] ? q[0][132:128] : 5'd0));
                if (ifc.ms_allowin) void'(q.pop_front());
            end
            if (exp_allowin && ifc.ds_to_es_valid) q.push_back(rb);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
